// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 PRGA/decrypt stage.
//   byte_t          8-bit data type used for S entries, keystream and message bytes
//   S_DEPTH         number of entries in the S permutation RAM
//   prga_state_t    per-byte PRGA loop states, one cycle each
//   is_valid_char   plaintext filter used by the optional key check: space or 'a'..'z'
package rc4_pkg;

    localparam int unsigned S_DEPTH = 256;

    typedef logic [$clog2(S_DEPTH)-1:0] byte_t;

    typedef enum logic [3:0] {
        IDLE,
        RD_SI,
        WAIT_SI,
        CAP_SI,
        RD_SJ,
        WAIT_SJ,
        CAP_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        WAIT_F,
        CAP_F,
        WR_OUT,
        DONE
    } prga_state_t;

    function automatic logic is_valid_char(byte_t c);
        return (c == 8'h20) || ((c >= 8'h61) && (c <= 8'h7a));
    endfunction

endpackage

// File: rtl/rc4_prga_datapath.sv
// RC4 PRGA datapath: holds i, j, k, si, sj, f and the ROM byte e, and decodes the current
// loop state into S RAM, encrypted ROM and decrypted RAM address/data.
//   clk, reset    system clock, synchronous active-high reset
//   state         current PRGA state from the controller
//   clear         clears i, j, k at the start of a run
//   s_rdata       S RAM read data (registered, 2 edges after address)
//   enc_rdata     encrypted ROM read data (same latency)
//   s_addr        S RAM address
//   s_wdata       S RAM write data
//   enc_addr      encrypted ROM address
//   dec_addr      decrypted RAM address
//   dec_wdata     plaintext byte (f ^ e), valid in WR_OUT
//   last_byte     the byte being written in WR_OUT is the final one of the message
module rc4_prga_datapath
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  prga_state_t       state,
    input  logic              clear,
    input  logic [7:0]        s_rdata,
    input  logic [7:0]        enc_rdata,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_wdata,
    output logic [MSG_AW-1:0] enc_addr,
    output logic [MSG_AW-1:0] dec_addr,
    output logic [7:0]        dec_wdata,
    output logic              last_byte
);

    // k carries one extra bit so MSG_LEN == 2**MSG_AW does not wrap to zero.
    localparam logic [MSG_AW:0] LAST_K = (MSG_AW + 1)'(MSG_LEN - 1);

    byte_t             i_q;
    byte_t             j_q;
    byte_t             si_q;
    byte_t             sj_q;
    byte_t             f_q;
    byte_t             e_q;
    logic [MSG_AW:0]   k_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            i_q  <= '0;
            j_q  <= '0;
            k_q  <= '0;
            si_q <= '0;
            sj_q <= '0;
            f_q  <= '0;
            e_q  <= '0;
        end else if (clear) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            case (state)
                RD_SI:  i_q <= i_q + 8'd1;
                CAP_SI: begin
                    si_q <= s_rdata;
                    j_q  <= j_q + s_rdata;
                end
                CAP_SJ: sj_q <= s_rdata;
                CAP_F: begin
                    f_q <= s_rdata;
                    e_q <= enc_rdata;
                end
                WR_OUT: k_q <= k_q + (MSG_AW + 1)'(1);
                default: ;
            endcase
        end
    end

    // Addresses are only driven in the states that use them; zero elsewhere.
    always_comb begin
        s_addr    = '0;
        s_wdata   = '0;
        enc_addr  = '0;
        dec_addr  = '0;
        dec_wdata = '0;
        case (state)
            RD_SI:  s_addr = i_q + 8'd1;
            RD_SJ:  s_addr = j_q;
            WR_SI: begin
                s_addr  = i_q;
                s_wdata = sj_q;
            end
            WR_SJ: begin
                s_addr  = j_q;
                s_wdata = si_q;
            end
            RD_F: begin
                // si + sj wraps mod 256, matching the 8-bit S index.
                s_addr   = si_q + sj_q;
                enc_addr = k_q[MSG_AW-1:0];
            end
            WR_OUT: begin
                dec_addr  = k_q[MSG_AW-1:0];
                dec_wdata = f_q ^ e_q;
            end
            default: ;
        endcase
    end

    assign last_byte = (k_q >= LAST_K);

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA decrypt stage. After the KSA has shuffled S, generates MSG_LEN keystream bytes,
// XORs each with the encrypted ROM and writes the plaintext to the decrypted RAM. Each
// message byte takes 12 single-cycle states; done is held until start drops.
//   clk, reset    system clock, synchronous active-high reset
//   start         level request, sampled in IDLE (and in DONE to return to IDLE)
//   done          high while in DONE
//   s_addr/s_wdata/s_wren/s_rdata          shared S RAM port (read latency 2 edges)
//   enc_addr/enc_rdata                     encrypted message ROM (same latency)
//   dec_addr/dec_wdata/dec_wren            decrypted message RAM write port
//   key_invalid   only with PRGA_ASCII_CHECK_EN: a plaintext byte outside {space, a..z}
//                 was seen; the run stops after writing that byte
// Optional feature macro: PRGA_ASCII_CHECK_EN
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_wdata,
    output logic              s_wren,
    input  logic [7:0]        s_rdata,
    output logic [MSG_AW-1:0] enc_addr,
    input  logic [7:0]        enc_rdata,
    output logic [MSG_AW-1:0] dec_addr,
    output logic [7:0]        dec_wdata,
    output logic              dec_wren
`ifdef PRGA_ASCII_CHECK_EN
    ,
    output logic              key_invalid
`endif
);

    prga_state_t state_q;
    prga_state_t state_d;
    logic        clear;
    logic        last_byte;

    assign clear = (state_q == IDLE) && start;

    rc4_prga_datapath #(
        .MSG_LEN (MSG_LEN),
        .MSG_AW  (MSG_AW)
    ) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .state     (state_q),
        .clear     (clear),
        .s_rdata   (s_rdata),
        .enc_rdata (enc_rdata),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .enc_addr  (enc_addr),
        .dec_addr  (dec_addr),
        .dec_wdata (dec_wdata),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RD_SI;
            RD_SI:   state_d = WAIT_SI;
            WAIT_SI: state_d = CAP_SI;
            CAP_SI:  state_d = RD_SJ;
            RD_SJ:   state_d = WAIT_SJ;
            WAIT_SJ: state_d = CAP_SJ;
            CAP_SJ:  state_d = WR_SI;
            WR_SI:   state_d = WR_SJ;
            WR_SJ:   state_d = RD_F;
            RD_F:    state_d = WAIT_F;
            WAIT_F:  state_d = CAP_F;
            CAP_F:   state_d = WR_OUT;
            WR_OUT: begin
                if (last_byte) begin
                    state_d = DONE;
                end else begin
                    state_d = RD_SI;
                end
`ifdef PRGA_ASCII_CHECK_EN
                // Byte is written this cycle regardless; a bad one ends the run.
                if (!is_valid_char(byte_t'(dec_wdata))) begin
                    state_d = DONE;
                end
`endif
            end
            DONE:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_wren   = (state_q == WR_SI) || (state_q == WR_SJ);
        dec_wren = (state_q == WR_OUT);
        done     = (state_q == DONE);
    end

`ifdef PRGA_ASCII_CHECK_EN
    logic key_invalid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_invalid_q <= 1'b0;
        end else if (clear) begin
            key_invalid_q <= 1'b0;
        end else if ((state_q == WR_OUT) && !is_valid_char(byte_t'(dec_wdata))) begin
            key_invalid_q <= 1'b1;
        end
    end

    assign key_invalid = key_invalid_q;
`endif

endmodule
